// File: rtl/adder_result_display.sv
// Captures the 5-bit adder result and shows it as two decimal digits on a muxed 7-seg display.
// Build option LEAD_ZERO_BLANK_EN blanks a zero tens digit.
module adder_result_display #(
    parameter int SCAN_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sum,
    input  logic       cout,
    input  logic       load,
    output logic [4:0] held_val,
    output logic       upd,
    output logic [1:0] an,
    output logic [6:0] seg
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);

    logic [4:0]    held_q, held_d;
    logic          upd_q, upd_d;
    logic [1:0]    tens_q, tens_d;
    logic [3:0]    ones_q, ones_d;
    logic [CW-1:0] scan_q, scan_d;
    logic          dsel_q, dsel_d;

    function automatic logic [6:0] enc(input logic [3:0] d);
        case (d)
            4'd0:    enc = 7'b1000000;
            4'd1:    enc = 7'b1111001;
            4'd2:    enc = 7'b0100100;
            4'd3:    enc = 7'b0110000;
            4'd4:    enc = 7'b0011001;
            4'd5:    enc = 7'b0010010;
            4'd6:    enc = 7'b0000010;
            4'd7:    enc = 7'b1111000;
            4'd8:    enc = 7'b0000000;
            4'd9:    enc = 7'b0010000;
            default: enc = 7'b1111111;
        endcase
    endfunction

    always_comb begin
        held_d = load ? {cout, sum} : held_q;
        upd_d  = load;

        // held value is at most 31, so three compares cover the tens digit
        if (held_q >= 5'd30) begin
            tens_d = 2'd3;
            ones_d = 4'(held_q - 5'd30);
        end else if (held_q >= 5'd20) begin
            tens_d = 2'd2;
            ones_d = 4'(held_q - 5'd20);
        end else if (held_q >= 5'd10) begin
            tens_d = 2'd1;
            ones_d = 4'(held_q - 5'd10);
        end else begin
            tens_d = 2'd0;
            ones_d = 4'(held_q);
        end

        if (scan_q == SCAN_LAST) begin
            scan_d = '0;
            dsel_d = ~dsel_q;
        end else begin
            scan_d = scan_q + CW'(1);
            dsel_d = dsel_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            held_q <= '0;
            upd_q  <= 1'b0;
            tens_q <= '0;
            ones_q <= '0;
            scan_q <= '0;
            dsel_q <= 1'b0;
        end else begin
            held_q <= held_d;
            upd_q  <= upd_d;
            tens_q <= tens_d;
            ones_q <= ones_d;
            scan_q <= scan_d;
            dsel_q <= dsel_d;
        end
    end

    always_comb begin
        if (dsel_q) begin
            an  = 2'b01;
            seg = enc({2'b00, tens_q});
`ifdef LEAD_ZERO_BLANK_EN
            if (tens_q == 2'd0) seg = 7'b1111111;
`endif
        end else begin
            an  = 2'b10;
            seg = enc(ones_q);
        end
    end

    assign held_val = held_q;
    assign upd      = upd_q;

endmodule

// File: tb/tb_adder_result_display.sv
// Directed bench for adder_result_display with SCAN_DIV=4.
// Honours LEAD_ZERO_BLANK_EN when defined.
module tb_adder_result_display;

    localparam int SD = 4;

    logic       clk;
    logic       rst;
    logic [3:0] sum;
    logic       cout;
    logic       load;
    logic [4:0] held_val;
    logic       upd;
    logic [1:0] an;
    logic [6:0] seg;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    logic [6:0] seg_tab [10];

    adder_result_display #(.SCAN_DIV(SD)) dut (
        .clk(clk), .rst(rst), .sum(sum), .cout(cout), .load(load),
        .held_val(held_val), .upd(upd), .an(an), .seg(seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic exp_dsel();
        return ((cyc / SD) % 2) == 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst) cyc = 0;
        else cyc++;
        @(negedge clk);
    endtask

    task automatic capture(input logic c, input logic [3:0] s);
        cout = c;
        sum  = s;
        load = 1'b1;
        tick();
        load = 1'b0;
        tick();
    endtask

    task automatic wait_slot(input logic d);
        for (int i = 0; i < 2 * SD + 2; i++)
            if (exp_dsel() != d) tick();
    endtask

    function automatic logic [6:0] tens_seg(input int t);
`ifdef LEAD_ZERO_BLANK_EN
        if (t == 0) return 7'b1111111;
`endif
        return seg_tab[t];
    endfunction

    task automatic check_disp(input string tag, input int t, input int o);
        wait_slot(1'b0);
        check({tag, "_an_ones"}, 32'(an), 32'(2'b10));
        check({tag, "_seg_ones"}, 32'(seg), 32'(seg_tab[o]));
        wait_slot(1'b1);
        check({tag, "_an_tens"}, 32'(an), 32'(2'b01));
        check({tag, "_seg_tens"}, 32'(seg), 32'(tens_seg(t)));
    endtask

    initial begin
        seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001;
        seg_tab[2] = 7'b0100100; seg_tab[3] = 7'b0110000;
        seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
        seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000;
        seg_tab[8] = 7'b0000000; seg_tab[9] = 7'b0010000;

        rst = 1'b1; load = 1'b0; sum = 4'd0; cout = 1'b0;
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;
        check("rst_held", 32'(held_val), 32'd0);
        check("rst_upd", 32'(upd), 32'd0);
        check("rst_an", 32'(an), 32'(2'b10));
        check("rst_seg", 32'(seg), 32'(7'b1000000));
        for (int i = 0; i < SD; i++) tick();
        check("rst_an_tens", 32'(an), 32'(2'b01));
        check("rst_seg_tens", 32'(seg), 32'(tens_seg(0)));

        // capture 25 and verify single-cycle upd
        cout = 1'b1; sum = 4'b1001; load = 1'b1;
        tick();
        load = 1'b0;
        check("c25_held", 32'(held_val), 32'd25);
        check("c25_upd_hi", 32'(upd), 32'd1);
        tick();
        check("c25_upd_lo", 32'(upd), 32'd0);
        check_disp("c25", 2, 5);

        capture(1'b1, 4'b1111);
        check("c31_held", 32'(held_val), 32'd31);
        check_disp("c31", 3, 1);

        capture(1'b0, 4'b1001);
        check("c9_held", 32'(held_val), 32'd9);
        check_disp("c9", 0, 9);

        // continuous load keeps upd high and tracks input
        cout = 1'b0; sum = 4'd3; load = 1'b1;
        tick();
        sum = 4'd7;
        tick();
        check("cont_upd", 32'(upd), 32'd1);
        check("cont_held", 32'(held_val), 32'd7);
        load = 1'b0;
        tick();

        capture(1'b0, 4'b1100);
        for (int i = 0; i < 50; i++) begin
            sum  = 4'($urandom_range(0, 15));
            cout = 1'($urandom_range(0, 1));
            tick();
            check("hold_held", 32'(held_val), 32'd12);
            check("hold_upd", 32'(upd), 32'd0);
        end
        check_disp("hold", 1, 2);

        // scan timing with a load dropped in mid-slot
        for (int i = 0; i < 40; i++) begin
            if (i == 10) begin
                cout = 1'b0; sum = 4'd4; load = 1'b1;
            end else begin
                load = 1'b0;
            end
            tick();
            check("scan_an", 32'(an), exp_dsel() ? 32'(2'b01) : 32'(2'b10));
            check("scan_an_nz", 32'(an != 2'b00 && an != 2'b11), 32'd1);
        end
        check("scan_held", 32'(held_val), 32'd4);

        capture(1'b1, 4'b1001);
        for (int i = 0; i < 4 * SD; i++)
            if (cyc % (2 * SD) != SD + 2) tick();
        check("mid_pre_an", 32'(an), 32'(2'b01));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_held", 32'(held_val), 32'd0);
        check("mid_an", 32'(an), 32'(2'b10));
        check("mid_seg", 32'(seg), 32'(7'b1000000));
        for (int i = 0; i < SD - 1; i++) tick();
        check("mid_an_last", 32'(an), 32'(2'b10));
        tick();
        check("mid_an_wrap", 32'(an), 32'(2'b01));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
